// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle; holds the pipeline through stallreq_o
// until the quotient or remainder is ready for the EX result mux.
module div_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              annul_i,
   input  logic              signed_i,
   input  logic              rem_i,
   input  logic [DATA_W-1:0] opdata1_i,
   input  logic [DATA_W-1:0] opdata2_i,
   output logic [DATA_W-1:0] result_o,
   output logic              ready_o,
   output logic              stallreq_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ON      = 2'd1,
      ST_SPECIAL = 2'd2,
      ST_END     = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] ALL_ZEROS = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Two's complement negation.
   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      return ~v + ONE;
   endfunction

   // Negate only when the recorded sign says the true result is negative.
   function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v,
                                                  input logic neg);
      return neg ? negate(v) : v;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [DATA_W-1:0] rem_r, rem_nxt_s;      // partial remainder
   logic [DATA_W-1:0] quo_r, quo_nxt_s;      // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0] div_r, div_nxt_s;      // divisor magnitude
   logic              neg_q_r, neg_q_nxt_s;
   logic              neg_r_r, neg_r_nxt_s;
   logic              rem_sel_r, rem_sel_nxt_s;
   logic [DATA_W-1:0] result_nxt_s;
   logic              ready_nxt_s;

   // Step datapath: the shifted remainder needs one extra bit before the compare.
   logic [DATA_W:0]   shift_s;
   logic [DATA_W:0]   diff_s;
   logic              step_ge_s;
   logic [DATA_W-1:0] step_rem_s;
   logic [DATA_W-1:0] step_quo_s;

   // Operand decode at request time.
   logic              sign1_s, sign2_s;
   logic [DATA_W-1:0] mag1_s, mag2_s;
   logic              div0_s, ovf_s;

   assign shift_s    = {rem_r, quo_r[DATA_W-1]};
   assign diff_s     = shift_s - {1'b0, div_r};
   // Since rem < divisor, a borrow out of the top bit means shift_s < divisor.
   assign step_ge_s  = ~diff_s[DATA_W];
   assign step_rem_s = step_ge_s ? diff_s[DATA_W-1:0] : shift_s[DATA_W-1:0];
   assign step_quo_s = {quo_r[DATA_W-2:0], step_ge_s};

   assign sign1_s = signed_i & opdata1_i[DATA_W-1];
   assign sign2_s = signed_i & opdata2_i[DATA_W-1];
   assign mag1_s  = sign_fix(opdata1_i, sign1_s);
   assign mag2_s  = sign_fix(opdata2_i, sign2_s);
   assign div0_s  = (opdata2_i == ALL_ZEROS);
   assign ovf_s   = signed_i & (opdata1_i == MIN_NEG) & (opdata2_i == ALL_ONES);

   assign stallreq_o = start_i & ~annul_i & (state_r != ST_END) & ~rst;

   // Next-state, datapath and output decode for the divide sequencer.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      rem_nxt_s     = rem_r;
      quo_nxt_s     = quo_r;
      div_nxt_s     = div_r;
      neg_q_nxt_s   = neg_q_r;
      neg_r_nxt_s   = neg_r_r;
      rem_sel_nxt_s = rem_sel_r;
      result_nxt_s  = result_o;
      ready_nxt_s   = ready_o;
      if (annul_i) begin
         state_nxt_s = ST_IDLE;
         ready_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ready_nxt_s = 1'b0;
               if (start_i) begin
                  rem_sel_nxt_s = rem_i;
                  cnt_nxt_s     = {CNT_W{1'b0}};
                  div_nxt_s     = mag2_s;
                  if (div0_s) begin
                     // Result is architecturally fixed; no sign fix afterwards.
                     state_nxt_s = ST_SPECIAL;
                     quo_nxt_s   = ALL_ONES;
                     rem_nxt_s   = opdata1_i;
                     neg_q_nxt_s = 1'b0;
                     neg_r_nxt_s = 1'b0;
                  end else if (ovf_s) begin
                     state_nxt_s = ST_SPECIAL;
                     quo_nxt_s   = MIN_NEG;
                     rem_nxt_s   = ALL_ZEROS;
                     neg_q_nxt_s = 1'b0;
                     neg_r_nxt_s = 1'b0;
                  end else begin
                     state_nxt_s = ST_ON;
                     quo_nxt_s   = mag1_s;
                     rem_nxt_s   = ALL_ZEROS;
                     neg_q_nxt_s = sign1_s ^ sign2_s;
                     neg_r_nxt_s = sign1_s;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ON: begin
               if (!start_i) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  rem_nxt_s = step_rem_s;
                  quo_nxt_s = step_quo_s;
                  cnt_nxt_s = cnt_r + CNT_ONE;
                  if (cnt_r == CNT_LAST) begin
                     state_nxt_s  = ST_END;
                     ready_nxt_s  = 1'b1;
                     result_nxt_s = rem_sel_r ? sign_fix(step_rem_s, neg_r_r)
                                              : sign_fix(step_quo_s, neg_q_r);
                  end else begin
                     state_nxt_s = ST_ON;
                  end
               end
            end
            ST_SPECIAL: begin
               if (!start_i) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s  = ST_END;
                  ready_nxt_s  = 1'b1;
                  result_nxt_s = rem_sel_r ? sign_fix(rem_r, neg_r_r)
                                           : sign_fix(quo_r, neg_q_r);
               end
            end
            ST_END: begin
               if (!start_i) begin
                  state_nxt_s = ST_IDLE;
                  ready_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_END;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               ready_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         rem_r     <= ALL_ZEROS;
         quo_r     <= ALL_ZEROS;
         div_r     <= ALL_ZEROS;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         rem_sel_r <= 1'b0;
         result_o  <= ALL_ZEROS;
         ready_o   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         rem_r     <= rem_nxt_s;
         quo_r     <= quo_nxt_s;
         div_r     <= div_nxt_s;
         neg_q_r   <= neg_q_nxt_s;
         neg_r_r   <= neg_r_nxt_s;
         rem_sel_r <= rem_sel_nxt_s;
         result_o  <= result_nxt_s;
         ready_o   <= ready_nxt_s;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: the driver pushes expected result and ready
// cycle per issued op; a negedge monitor pops on each rising ready_o.
module tb_div_ctrl;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start_i, annul_i, signed_i, rem_i;
   logic [W-1:0] opdata1_i, opdata2_i, result_o;
   logic         ready_o, stallreq_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0] val;
      int           cyc;
   } exp_t;
   exp_t sb_q[$];

   div_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
      .signed_i(signed_i), .rem_i(rem_i), .opdata1_i(opdata1_i),
      .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o),
      .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency expectations.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: RV32M semantics with plain arithmetic.
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input bit s, input bit r);
      if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
      if (s) return r ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
      return r ? (a % b) : (a / b);
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
      if (b == 32'd0) return 2;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 33;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every rising ready_o against the scoreboard head.
   initial begin
      automatic logic ready_q = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && ready_o && !ready_q) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ready: got ready_o=1 expected no pending op (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               check("result", result_o, e.val);
               check("latency", 32'(cyc), 32'(e.cyc));
            end
         end
         ready_q = rst ? 1'b0 : ready_o;
      end
   end

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit r);
      opdata1_i = a;
      opdata2_i = b;
      signed_i  = s;
      rem_i     = r;
      start_i   = 1'b1;
   endtask

   // Full op: issue, wait for ready with cycle bound, hold, release.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit r, input int hold, input bit scramble);
      int n;
      logic [W-1:0] exp_v;
      exp_v = ref_div(a, b, s, r);
      tick();
      launch(a, b, s, r);
      sb_q.push_back('{exp_v, cyc + ref_lat(a, b, s)});
      #1;
      check("stall_c0", 32'(stallreq_o), 32'd1);
      n = 0;
      while (!ready_o && n < 100) begin
         tick();
         if (scramble) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
         if (!ready_o) begin
            if (stallreq_o !== 1'b1) check("stall_busy", 32'(stallreq_o), 32'd1);
         end
         n++;
      end
      if (!ready_o) begin
         check("ready_timeout", 32'(ready_o), 32'd1);
         start_i = 1'b0;
         return;
      end
      check("stall_end", 32'(stallreq_o), 32'd0);
      repeat (hold) begin
         tick();
         check("hold_ready", 32'(ready_o), 32'd1);
         check("hold_result", result_o, exp_v);
         check("hold_stall", 32'(stallreq_o), 32'd0);
      end
      start_i = 1'b0;
      tick();
      check("ready_drop", 32'(ready_o), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start_i   = 1'b1;
      annul_i   = 1'b0;
      signed_i  = 1'b0;
      rem_i     = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      repeat (3) tick();
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_stall", 32'(stallreq_o), 32'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      tick();

      // Directed cases
      do_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b0);
      do_op(32'd100, 32'd7, 1'b0, 1'b1, 0, 1'b0);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 1'b0);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, 1'b0);
      do_op(32'd5, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      do_op(32'd5, 32'd0, 1'b0, 1'b1, 0, 1'b0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
      do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 1, 1'b0);
      do_op(32'd12345, 32'hFFFF_FFFD, 1'b1, 1'b0, 0, 1'b0);

      // Annul at cycle 10: back to IDLE, no result for this op
      tick();
      launch(32'd100, 32'd7, 1'b0, 1'b0);
      repeat (10) tick();
      annul_i = 1'b1;
      #1;
      check("stall_annul", 32'(stallreq_o), 32'd0);
      tick();
      annul_i = 1'b0;
      start_i = 1'b0;
      repeat (40) tick();
      check("annul_no_ready", 32'(ready_o), 32'd0);
      do_op(32'd9, 32'd3, 1'b0, 1'b0, 0, 1'b0);

      // Dropping start mid-ON abandons the op
      tick();
      launch(32'd77, 32'd5, 1'b0, 1'b0);
      repeat (5) tick();
      start_i = 1'b0;
      repeat (40) tick();
      check("drop_no_ready", 32'(ready_o), 32'd0);

      // Reset pulse mid-ON at cycle 15 (result_o still holds 3 from 9/3)
      tick();
      launch(32'd100, 32'd7, 1'b0, 1'b0);
      repeat (15) tick();
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready_o), 32'd0);
      check("midrst_result", result_o, 32'd0);
      check("midrst_stall", 32'(stallreq_o), 32'd0);
      tick();
      rst     = 1'b0;
      start_i = 1'b0;
      tick();
      do_op(32'd1000, 32'd10, 1'b0, 1'b0, 0, 1'b0);

      // Operand changes mid-op and hold after ready
      do_op(32'd100, 32'd7, 1'b0, 1'b0, 3, 1'b1);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 3, 1'b1);

      // Randomized ops
      for (int i = 0; i < 25; i++) begin
         logic [W-1:0] a, b;
         int sel;
         a   = $urandom;
         sel = $urandom_range(0, 5);
         case (sel)
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: b = $urandom;
         endcase
         do_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (3) tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
